// File: rtl/fxlms_weight_update.sv
// rtl/fxlms_weight_update.sv - serial FxLMS weight-update engine, one tap per clock
module fxlms_weight_update #(
   parameter int N        = 32,
   parameter int DATA_W   = 32,
   parameter int FRAC     = 31,
   parameter int MU_SHIFT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     xf_in,
   input  logic [DATA_W-1:0]     e_in,
   input  logic                  freeze,
   input  logic [$clog2(N)-1:0]  w_rd_addr,
   output logic [DATA_W-1:0]     w_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);
   localparam int AW = $clog2(N);

   typedef enum logic {IDLE, UPD} state_t;
   state_t state_q, state_d;

   logic signed [DATA_W-1:0]   hist [N];
   logic signed [DATA_W-1:0]   w    [N];
   logic [AW-1:0]              wp, idx, tap, hist_sel;
   logic signed [DATA_W-1:0]   mu_e_r, mu_e_in, x_op, mu_op, w_old, w_new, prod;
   logic signed [2*DATA_W-1:0] mu_ext, x_ext, p;
   logic signed [DATA_W:0]     sum;
   logic                       freeze_r, accept, drop, last_tap, wr_en;
   logic                       unused_p_bits;

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      drop     = 1'b0;
      last_tap = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               accept  = 1'b1;
               state_d = UPD;
            end
         end
         UPD: begin
            drop = valid_in;
            if (idx == AW'(N - 1)) begin
               last_tap = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // wp has already advanced past the newest sample, so tap i sits at wp-1-i
   assign mu_e_in  = $signed(e_in) >>> MU_SHIFT;
   assign hist_sel = wp - idx - AW'(1);
   assign tap      = accept ? '0 : idx;
   assign x_op     = accept ? $signed(xf_in) : hist[hist_sel];
   assign mu_op    = accept ? mu_e_in : mu_e_r;
   assign w_old    = w[tap];

   assign mu_ext = {{DATA_W{mu_op[DATA_W-1]}}, mu_op};
   assign x_ext  = {{DATA_W{x_op[DATA_W-1]}}, x_op};
   assign p      = mu_ext * x_ext;
   assign prod   = p[FRAC +: DATA_W];
   assign unused_p_bits = ^{p[2*DATA_W-1 : FRAC+DATA_W], p[FRAC-1:0]};

   assign sum   = {w_old[DATA_W-1], w_old} + {prod[DATA_W-1], prod};
   assign w_new = (sum[DATA_W] != sum[DATA_W-1])
                ? (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                : sum[DATA_W-1:0];

   assign wr_en = (accept && !freeze) || (state_q == UPD && !freeze_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            hist[i] <= '0;
            w[i]    <= '0;
         end
         wp        <= '0;
         idx       <= '0;
         mu_e_r    <= '0;
         freeze_r  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         w_rd_data <= '0;
      end else begin
         w_rd_data <= w[w_rd_addr];
         done      <= last_tap;
         if (drop) ovf <= 1'b1;
         if (accept) begin
            hist[wp] <= $signed(xf_in);
            wp       <= wp + AW'(1);
            mu_e_r   <= mu_e_in;
            freeze_r <= freeze;
            idx      <= AW'(1);
            busy     <= 1'b1;
         end else if (state_q == UPD) begin
            idx <= idx + AW'(1);
            if (last_tap) busy <= 1'b0;
         end
         if (wr_en) w[tap] <= w_new;
      end
   end
endmodule
